// File: rtl/exe_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage_pkg
// Description : Shared widths, ALU op codes, memory-size codes, load/store
//               FSM states and pipeline-bus layouts for the RV32 execute stage.
//               Also provides the load lane-select / extension helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package exe_stage_pkg;

  localparam int XLEN         = 32;
  localparam int PC_WIDTH     = 32;
  localparam int ALU_OP_WIDTH = 4;

  // ALU operation codes
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL   = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL   = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT   = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS2 = 4'd10;

  // Memory access size codes
  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  // Load/store handshake FSM
  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_REQ  = 2'd1,
    LS_WAIT = 2'd2,
    LS_DONE = 2'd3
  } ls_state_t;

  // ID -> EXE payload (first field is the MSB end of the bus)
  typedef struct packed {
    logic [PC_WIDTH-1:0]     pc;
    logic [XLEN-1:0]         src1;
    logic [XLEN-1:0]         src2;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [1:0]              rf_wr_sel;
    logic                    rf_wr_en;
    logic [4:0]              reg_waddr;
    logic                    mem_ren;
    logic                    mem_wen;
    logic [1:0]              mem_size;
    logic                    mem_unsigned;
    logic [XLEN-1:0]         store_data;
    logic                    inst_ebreak;
  } id_to_exe_t;

  // EXE -> MEM payload
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [XLEN-1:0]     alu_result;
    logic [1:0]          rf_wr_sel;
    logic                rf_wr_en;
    logic [4:0]          reg_waddr;
    logic [XLEN-1:0]     load_data;
    logic                inst_ebreak;
  } exe_to_mem_t;

  // EXE -> ID forwarding payload
  typedef struct packed {
    logic            wr_valid;
    logic [4:0]      reg_waddr;
    logic [XLEN-1:0] alu_result;
  } bypass_t;

  localparam int ID_TO_EXE_BUS_WIDTH  = $bits(id_to_exe_t);
  localparam int EXE_TO_MEM_BUS_WIDTH = $bits(exe_to_mem_t);
  localparam int BYPASS_BUS_WIDTH     = $bits(bypass_t);

  // Pick the addressed lane out of a read word and extend it to XLEN.
  function automatic logic [XLEN-1:0] load_extend(
    input logic [XLEN-1:0] rdata,
    input logic [1:0]      offs,
    input logic [1:0]      size,
    input logic            is_unsigned
  );
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] res;
    lane = rdata >> {offs, 3'b000};
    case (size)
      MEM_SIZE_B: res = is_unsigned ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      MEM_SIZE_H: res = is_unsigned ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default:    res = rdata;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exe_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage_if
// Description : Request/response channel between the execute stage and the
//               data SRAM.
// Ports       : master - data_req, data_wr, data_wstrb, data_addr, data_wdata
//                        out; data_addr_ok, data_data_ok, data_rdata in.
//               slave  - mirror image of master.
// Revision    : 1.0 - initial release
// ============================================================================
interface exe_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface
`default_nettype wire

// File: rtl/exe_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage_alu
// Description : Pure combinational RV32 ALU for the execute stage.
// Ports       : i_src1, i_src2 - operands (XLEN)
//               i_alu_op       - operation code (ALU_OP_WIDTH)
//               o_result       - result (XLEN); undefined codes yield 0
// Revision    : 1.0 - initial release
// ============================================================================
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [XLEN-1:0]         i_src1,
  input  logic [XLEN-1:0]         i_src2,
  input  logic [ALU_OP_WIDTH-1:0] i_alu_op,
  output logic [XLEN-1:0]         o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_src2[4:0];

  always_comb begin
    o_result = '0;
    case (i_alu_op)
      ALU_ADD:   o_result = i_src1 + i_src2;
      ALU_SUB:   o_result = i_src1 - i_src2;
      ALU_SLL:   o_result = i_src1 << w_shamt;
      ALU_SRL:   o_result = i_src1 >> w_shamt;
      ALU_SRA:   o_result = $unsigned($signed(i_src1) >>> w_shamt);
      ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, ($signed(i_src1) < $signed(i_src2))};
      ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, (i_src1 < i_src2)};
      ALU_XOR:   o_result = i_src1 ^ i_src2;
      ALU_OR:    o_result = i_src1 | i_src2;
      ALU_AND:   o_result = i_src1 & i_src2;
      ALU_PASS2: o_result = i_src2;
      default:   o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage
// Description : Execute stage of the five-stage RV32 pipeline. Computes the
//               ALU result, runs data-SRAM loads/stores over a req/ack
//               handshake, and delivers aligned, extended load data to MEM.
// Ports       : clk, rst (async, active-low)
//               id_to_exe_valid / exe_allow_in / id_to_exe_bus  - from ID
//               mem_allow_in / exe_to_mem_valid / exe_to_mem_bus - to MEM
//               exe_valid, exe_to_id_bypass_bus, exe_is_load     - to ID
//               exe_misalign - current memory access is misaligned
//               data_if (master) - data SRAM request/response channel
// Revision    : 1.0 - initial release
// ============================================================================
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_to_exe_valid,
  output logic                            exe_allow_in,
  input  logic                            mem_allow_in,
  output logic                            exe_to_mem_valid,
  input  logic [ID_TO_EXE_BUS_WIDTH-1:0]  id_to_exe_bus,
  output logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
  output logic                            exe_valid,
  output logic [BYPASS_BUS_WIDTH-1:0]     exe_to_id_bypass_bus,
  output logic                            exe_is_load,
  output logic                            exe_misalign,
  exe_stage_if.master                     data_if
);

  id_to_exe_t      r_exe_reg;
  logic            r_exe_valid;
  ls_state_t       r_ls_state;
  ls_state_t       w_ls_state_nxt;
  logic [XLEN-1:0] r_rdata_buf;

  logic [XLEN-1:0] w_alu_result;
  logic [1:0]      w_offs;
  logic            w_is_mem;
  logic            w_misalign;
  logic            w_mem_access;
  logic            w_ready_go;
  logic            w_data_req;
  logic            w_capture;
  logic            w_store;
  exe_to_mem_t     w_to_mem;
  bypass_t         w_bypass;

  exe_stage_alu u_alu (
    .i_src1   (r_exe_reg.src1),
    .i_src2   (r_exe_reg.src2),
    .i_alu_op (r_exe_reg.alu_op),
    .o_result (w_alu_result)
  );

  // --------------------------------------------------------------------------
  // Pipeline register and valid bit
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exe_valid <= 1'b0;
    end else if (exe_allow_in) begin
      r_exe_valid <= id_to_exe_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exe_reg <= '0;
    end else if (exe_allow_in && id_to_exe_valid) begin
      r_exe_reg <= id_to_exe_t'(id_to_exe_bus);
    end
  end

  // --------------------------------------------------------------------------
  // Address decode; the address is always the ALU sum
  // --------------------------------------------------------------------------
  assign w_offs   = w_alu_result[1:0];
  assign w_is_mem = r_exe_reg.mem_ren | r_exe_reg.mem_wen;

  always_comb begin
    w_misalign = 1'b0;
    case (r_exe_reg.mem_size)
      MEM_SIZE_B: w_misalign = 1'b0;
      MEM_SIZE_H: w_misalign = w_offs[0];
      default:    w_misalign = |w_offs;
    endcase
  end

  // A misaligned access is retired like an ALU op and never reaches the SRAM.
  assign w_mem_access = w_is_mem & ~w_misalign;

  // --------------------------------------------------------------------------
  // Load/store FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ls_state <= LS_IDLE;
    end else begin
      r_ls_state <= w_ls_state_nxt;
    end
  end

  always_comb begin
    w_ls_state_nxt = r_ls_state;
    w_data_req     = 1'b0;
    w_ready_go     = 1'b0;
    w_capture      = 1'b0;
    case (r_ls_state)
      LS_IDLE: begin
        w_ready_go = ~w_mem_access;
        if (r_exe_valid && w_mem_access) begin
          w_data_req     = 1'b1;
          w_ls_state_nxt = data_if.data_addr_ok ? LS_WAIT : LS_REQ;
        end
      end
      LS_REQ: begin
        // Request fields come straight from exe_reg, which cannot change
        // until handoff, so they stay stable while we wait for addr_ok.
        w_data_req = 1'b1;
        if (data_if.data_addr_ok) begin
          w_ls_state_nxt = LS_WAIT;
        end
      end
      LS_WAIT: begin
        if (data_if.data_data_ok) begin
          w_capture      = 1'b1;
          w_ls_state_nxt = LS_DONE;
        end
      end
      LS_DONE: begin
        w_ready_go = 1'b1;
        if (mem_allow_in) begin
          w_ls_state_nxt = LS_IDLE;
        end
      end
      default: w_ls_state_nxt = LS_IDLE;
    endcase
  end

  // Registering the extended data keeps data_rdata off every output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata_buf <= '0;
    end else if (w_capture) begin
      r_rdata_buf <= load_extend(data_if.data_rdata, w_offs,
                                 r_exe_reg.mem_size, r_exe_reg.mem_unsigned);
    end
  end

  // --------------------------------------------------------------------------
  // SRAM request channel
  // --------------------------------------------------------------------------
  assign w_store            = r_exe_valid & r_exe_reg.mem_wen & ~w_misalign;
  assign data_if.data_req   = w_data_req;
  assign data_if.data_wr    = w_store;
  assign data_if.data_addr  = w_alu_result;

  always_comb begin
    data_if.data_wdata = r_exe_reg.store_data;
    data_if.data_wstrb = 4'b0000;
    case (r_exe_reg.mem_size)
      MEM_SIZE_B: begin
        data_if.data_wdata = {4{r_exe_reg.store_data[7:0]}};
        data_if.data_wstrb = 4'b0001 << w_offs;
      end
      MEM_SIZE_H: begin
        data_if.data_wdata = {2{r_exe_reg.store_data[15:0]}};
        data_if.data_wstrb = 4'b0011 << w_offs;
      end
      default: begin
        data_if.data_wdata = r_exe_reg.store_data;
        data_if.data_wstrb = 4'b1111;
      end
    endcase
    if (!w_store) begin
      data_if.data_wstrb = 4'b0000;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline handshake and outputs
  // --------------------------------------------------------------------------
  assign exe_valid        = r_exe_valid;
  assign exe_allow_in     = ~r_exe_valid | (w_ready_go & mem_allow_in);
  assign exe_to_mem_valid = r_exe_valid & w_ready_go;
  assign exe_is_load      = r_exe_valid & r_exe_reg.mem_ren;
  assign exe_misalign     = r_exe_valid & w_is_mem & w_misalign;

  always_comb begin
    w_to_mem.pc          = r_exe_reg.pc;
    w_to_mem.alu_result  = w_alu_result;
    w_to_mem.rf_wr_sel   = r_exe_reg.rf_wr_sel;
    w_to_mem.rf_wr_en    = r_exe_reg.rf_wr_en;
    w_to_mem.reg_waddr   = r_exe_reg.reg_waddr;
    w_to_mem.load_data   = (r_exe_reg.mem_ren && !w_misalign) ? r_rdata_buf : '0;
    w_to_mem.inst_ebreak = r_exe_reg.inst_ebreak;
  end

  assign exe_to_mem_bus = w_to_mem;

  assign w_bypass.wr_valid   = r_exe_valid & r_exe_reg.rf_wr_en;
  assign w_bypass.reg_waddr  = r_exe_reg.reg_waddr;
  assign w_bypass.alu_result = w_alu_result;
  assign exe_to_id_bypass_bus = w_bypass;

endmodule
`default_nettype wire
